// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

  localparam int unsigned NUM_COMB = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StDone
  } state_e;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// 8-bit load/down-counter with a zero flag; stops at zero.
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Drives all 8 input combinations of a 3-input gate, captures its truth table and
// compares it with a golden value. Define TT_SWEEP_DIAG_EN for mismatch diagnostics.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] tt
`ifdef TT_SWEEP_DIAG_EN
  ,
  output logic [3:0] mismatch_cnt,
  output logic [2:0] first_fail
`endif
);

  state_e           r_state;
  state_e           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_drv;
  logic [7:0]       r_exp;
  logic [7:0]       r_tt;
  logic             r_pass;
  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic             w_match;

  assign w_accept = (r_state == StIdle) && start && !abort;
  assign w_last   = (r_idx == IDX_W'(NUM_COMB - 1));
  assign w_match  = (r_tt == r_exp);

  // Loaded with N-1 in DRIVE so SETTLE lasts exactly N cycles.
  tt_settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == StDrive),
    .i_load_val (8'(SETTLE_CYCLES - 1)),
    .i_dec      (r_state == StSettle),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = StDrive;
      StDrive:  w_state_next = StSettle;
      StSettle: if (w_zero) w_state_next = StSample;
      StSample: w_state_next = w_last ? StDone : StDrive;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
    if (abort) w_state_next = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_drv  <= '0;
      r_exp  <= '0;
      r_tt   <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_accept) begin
        r_exp  <= expected;
        r_tt   <= '0;
        r_idx  <= '0;
        r_pass <= 1'b0;
      end
      if ((r_state == StDrive) && !abort) r_drv <= r_idx;
      if ((r_state == StSample) && !abort) begin
        r_tt[r_idx] <= dut_out;
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
      if ((r_state == StDone) && !abort) r_pass <= w_match;
    end
  end

`ifdef TT_SWEEP_DIAG_EN
  logic [7:0] w_diff;
  logic [3:0] r_mcnt;
  logic [2:0] r_ffail;

  assign w_diff = r_tt ^ r_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcnt  <= '0;
      r_ffail <= '0;
    end else if (w_accept) begin
      r_mcnt  <= '0;
      r_ffail <= '0;
    end else if ((r_state == StDone) && !abort) begin
      r_mcnt  <= count_ones(w_diff);
      r_ffail <= lowest_set(w_diff);
    end
  end
`endif

  // Results are visible combinationally during the DONE cycle, then held in registers.
  always_comb begin
    busy = (r_state == StDrive) || (r_state == StSettle) || (r_state == StSample);
    done = (r_state == StDone);
    pass = (r_state == StDone) ? w_match : r_pass;
`ifdef TT_SWEEP_DIAG_EN
    mismatch_cnt = (r_state == StDone) ? count_ones(w_diff) : r_mcnt;
    first_fail   = (r_state == StDone) ? lowest_set(w_diff) : r_ffail;
`endif
  end

  assign {dut_in1, dut_in2, dut_in3} = r_drv;
  assign tt = r_tt;

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 Parameter SHALL be: SETTLE_CYCLES, 2, wait cycles (legal 1..255) between driving an input combination and sampling the gate output.
REQ-002 Port clk SHALL be: input, 1, single clock, rising edge.
REQ-003 Port rst SHALL be: input, 1, asynchronous, active-high reset.
REQ-004 Port start SHALL be: input, 1, request a full 8-combination sweep.
REQ-005 Port abort SHALL be: input, 1, cancel a sweep in progress.
REQ-006 Port expected SHALL be: input, 8, golden truth table (for example 8'hA4), sampled when start is accepted.
REQ-007 Ports dut_in1, dut_in2, dut_in3 SHALL be: output, 1 each, registered drives to the 3-input gate netlist.
REQ-008 Port dut_out SHALL be: input, 1, gate output under test.
REQ-009 Port busy SHALL be: output, 1, high while a sweep is in progress.
REQ-010 Port done SHALL be: output, 1, single-cycle pulse when a sweep completes.
REQ-011 Port pass SHALL be: output, 1, high when tt equals the latched expected value.
REQ-012 Port tt SHALL be: output, 8, captured truth table.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-014 Index mapping for idx 0..7 SHALL be {dut_in1, dut_in2, dut_in3} = idx[2:0], with dut_out captured into tt[idx].
REQ-015 In IDLE with start=1 and abort=0, the block SHALL latch expected, clear tt, set idx=0 and enter DRIVE; busy SHALL be 1 from the next cycle.
REQ-016 DRIVE SHALL register the dut_in* drives from idx for 1 cycle, then enter SETTLE.
REQ-017 SETTLE SHALL hold for exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-018 SAMPLE SHALL write dut_out to tt[idx]; if idx=7 it SHALL enter DONE, otherwise it SHALL increment idx and enter DRIVE.
REQ-019 A sweep SHALL last exactly 8*(SETTLE_CYCLES+2) cycles from the start-accept edge to DONE entry.
REQ-020 In DONE, done SHALL be 1 for 1 cycle and busy SHALL be 0; the block SHALL then return to IDLE.
REQ-021 pass SHALL be computed in DONE and held, together with tt, until the next accepted start or reset.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 If abort=1 in any non-IDLE state, the next state SHALL be IDLE with done=0, pass=0 and tt retaining partial data.
REQ-024 If abort=1 and start=1 together in IDLE, abort SHALL win and no sweep SHALL start.
REQ-025 If start=1 in the DONE cycle, it SHALL be ignored and must be reasserted in IDLE.
REQ-026 dut_in* SHALL hold their last value while in IDLE.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, idx=0, dut_in*=0, busy=0, done=0, pass=0, tt=8'h00, latched expected=8'h00, and any diagnostic outputs=0.
REQ-028 Reset asserted mid-sweep SHALL discard the sweep, with no done pulse.

Configuration
REQ-029 With macro TT_SWEEP_DIAG_EN defined, the block SHALL add ports mismatch_cnt (output, 4, count of bits where tt differs from expected, valid from DONE) and first_fail (output, 3, lowest mismatching idx, 0 when pass=1).
REQ-030 Without TT_SWEEP_DIAG_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package tt_sweep_pkg SHALL hold the state enum, NUM_COMB=8 and IDX_W=3.
REQ-032 Sub-module tt_settle_timer SHALL be an 8-bit load/down-counter with a zero flag, instantiated once for SETTLE.

Verification
REQ-033 AND3 model, expected=8'h80, SETTLE_CYCLES=2 -> tt=8'h80, pass=1, done pulse 32 cycles after start accept.
REQ-034 XOR3 model, expected=8'h96 -> tt=8'h96, pass=1; with expected=8'h97 -> pass=0, and with DIAG mismatch_cnt=1, first_fail=0.
REQ-035 abort asserted at idx=4 -> IDLE next cycle, done never pulses, pass=0, tt[3:0] holds the sampled bits.
REQ-036 start held high through a sweep and its DONE cycle -> exactly one done pulse; the second sweep starts only after IDLE.
REQ-037 rst pulsed mid-SETTLE -> all outputs 0 immediately (asynchronous); a new start then produces a normal sweep.
REQ-038 SETTLE_CYCLES=1 with a model whose output lags its inputs by 1 cycle -> correct tt; sweep length 24 cycles.
